// File: rtl/sched_pkg.sv
// rtl/sched_pkg.sv - shared mode encodings and width helpers for the packet queue scheduler
package sched_pkg;

  // Drain policy selected by comparing the two scores
  localparam logic MODE_LAT = 1'b0;
  localparam logic MODE_REL = 1'b1;

  // Bits needed to name one of num_ch channels
  function automatic int ch_width(input int num_ch);
    return $clog2(num_ch);
  endfunction

  // Bits needed to hold an occupancy of 0..depth
  function automatic int occ_width(input int depth);
    return $clog2(depth + 1);
  endfunction

  // Bits needed for the largest weighted occupancy sum: depth * (1 + 2 + ... + num_ch)
  function automatic int score_width(input int num_ch, input int depth);
    return $clog2(depth * num_ch * (num_ch + 1) / 2 + 1);
  endfunction

endpackage

// File: rtl/channel_fifo.sv
// rtl/channel_fifo.sv - per-channel shift-register FIFO that discards its oldest entry on overflow
module channel_fifo
  import sched_pkg::*;
#(
  parameter int DEPTH  = 6,
  parameter int DATA_W = 2,
  localparam int OCC_W = occ_width(DEPTH)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              push,
  input  logic [DATA_W-1:0] push_data,
  input  logic              pop,
  output logic [DATA_W-1:0] head,
  output logic [OCC_W-1:0]  occ,
  output logic              drop
);

  // Entry 0 is always the oldest; valid entries occupy 0..r_occ-1
  logic [DATA_W-1:0] r_mem [DEPTH];
  logic [OCC_W-1:0]  r_occ;
  logic              r_drop;

  logic [DATA_W-1:0] w_mem_nxt [DEPTH];
  logic [OCC_W-1:0]  w_occ_nxt;
  logic [OCC_W-1:0]  w_wr_idx;
  logic              w_drop_nxt;
  logic              w_full;
  logic              w_pop_eff;
  logic              w_shift;

  assign w_full    = (r_occ == OCC_W'(DEPTH));
  // A pop on an empty queue is ignored, even if a push lands in the same cycle
  assign w_pop_eff = pop && (r_occ != '0);

  // Next contents: shift the head out on a pop or an overflow, then write the new entry behind the survivors
  always_comb begin
    w_shift    = w_pop_eff || (push && w_full);
    w_occ_nxt  = r_occ;
    w_drop_nxt = 1'b0;
    w_wr_idx   = r_occ;
    if (push && w_pop_eff) begin
      w_wr_idx = r_occ - OCC_W'(1);
    end else if (push && w_full) begin
      w_wr_idx   = OCC_W'(DEPTH - 1);
      w_drop_nxt = 1'b1;
    end else if (push) begin
      w_occ_nxt = r_occ + OCC_W'(1);
    end else if (w_pop_eff) begin
      w_occ_nxt = r_occ - OCC_W'(1);
    end
    for (int i = 0; i < DEPTH - 1; i++) begin
      w_mem_nxt[i] = w_shift ? r_mem[i+1] : r_mem[i];
    end
    w_mem_nxt[DEPTH-1] = r_mem[DEPTH-1];
    for (int i = 0; i < DEPTH; i++) begin
      if (push && (w_wr_idx == OCC_W'(i))) begin
        w_mem_nxt[i] = push_data;
      end
    end
  end

  // Storage, occupancy and the one-cycle drop pulse
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < DEPTH; i++) begin
        r_mem[i] <= '0;
      end
      r_occ  <= '0;
      r_drop <= 1'b0;
    end else begin
      for (int i = 0; i < DEPTH; i++) begin
        r_mem[i] <= w_mem_nxt[i];
      end
      r_occ  <= w_occ_nxt;
      r_drop <= w_drop_nxt;
    end
  end

  assign head = r_mem[0];
  assign occ  = r_occ;
  assign drop = r_drop;

endmodule

// File: rtl/packet_queue_scheduler.sv
// rtl/packet_queue_scheduler.sv - serial packet assembler, per-channel queues and score-driven drain scheduler
module packet_queue_scheduler
  import sched_pkg::*;
#(
  parameter int NUM_CH   = 4,
  parameter int DEPTH    = 6,
  parameter int DATA_W   = 2,
  parameter int TICK_DIV = 150000000,
  localparam int CH_W    = ch_width(NUM_CH),
  localparam int OCC_W   = occ_width(DEPTH),
  localparam int SC_W    = score_width(NUM_CH, DEPTH)
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    in_valid,
  input  logic                    in_bit,
  output logic                    out_valid,
  output logic [CH_W-1:0]         out_ch,
  output logic [DATA_W-1:0]       out_data,
  output logic [NUM_CH*OCC_W-1:0] occ,
  output logic [SC_W-1:0]         rel_score,
  output logic [SC_W-1:0]         lat_score,
  output logic                    mode,
  output logic                    drop
);

  localparam int PKT_W  = CH_W + DATA_W;
  localparam int BCNT_W = $clog2(PKT_W);
  localparam int TCNT_W = $clog2(TICK_DIV);

  // Assembler: the register keeps the first PKT_W-1 bits, the last bit is taken straight from in_bit
  logic [PKT_W-2:0]  r_shift;
  logic [BCNT_W-1:0] r_bitcnt;
  logic [PKT_W-1:0]  w_pkt;
  logic              w_pkt_done;
  logic [CH_W-1:0]   w_pkt_ch;
  logic [DATA_W-1:0] w_pkt_data;

  assign w_pkt      = {r_shift, in_bit};
  assign w_pkt_done = in_valid && (r_bitcnt == BCNT_W'(PKT_W - 1));
  assign w_pkt_ch   = w_pkt[PKT_W-1 -: CH_W];
  assign w_pkt_data = w_pkt[DATA_W-1:0];

  // Shift in one bit per in_valid and restart the bit count after the final bit
  always_ff @(posedge clk) begin
    if (rst) begin
      r_shift  <= '0;
      r_bitcnt <= '0;
    end else if (in_valid) begin
      r_shift  <= w_pkt[PKT_W-2:0];
      r_bitcnt <= w_pkt_done ? '0 : r_bitcnt + BCNT_W'(1);
    end
  end

  // Drain tick: one cycle in every TICK_DIV
  logic [TCNT_W-1:0] r_tick_cnt;
  logic              w_tick;

  assign w_tick = (r_tick_cnt == TCNT_W'(TICK_DIV - 1));

  // Free-running tick divider, restarted by reset
  always_ff @(posedge clk) begin
    if (rst) begin
      r_tick_cnt <= '0;
    end else if (w_tick) begin
      r_tick_cnt <= '0;
    end else begin
      r_tick_cnt <= r_tick_cnt + TCNT_W'(1);
    end
  end

  // Channel queues
  logic [DATA_W-1:0] w_head [NUM_CH];
  logic [OCC_W-1:0]  w_occ  [NUM_CH];
  logic [NUM_CH-1:0] w_push_vec;
  logic [NUM_CH-1:0] w_pop_vec;
  logic [NUM_CH-1:0] w_drop_vec;
  logic [CH_W-1:0]   w_sel_ch;
  logic [OCC_W-1:0]  w_sel_occ;
  logic              w_pop_go;

  for (genvar g = 0; g < NUM_CH; g++) begin : g_ch
    assign w_push_vec[g] = w_pkt_done && (w_pkt_ch == CH_W'(g));
    assign w_pop_vec[g]  = w_pop_go && (w_sel_ch == CH_W'(g));

    channel_fifo #(
      .DEPTH  (DEPTH),
      .DATA_W (DATA_W)
    ) u_fifo (
      .clk       (clk),
      .rst       (rst),
      .push      (w_push_vec[g]),
      .push_data (w_pkt_data),
      .pop       (w_pop_vec[g]),
      .head      (w_head[g]),
      .occ       (w_occ[g]),
      .drop      (w_drop_vec[g])
    );

    assign occ[g*OCC_W +: OCC_W] = w_occ[g];
  end

  assign drop = |w_drop_vec;

  // Scores: high channels weigh more for reliability, low channels weigh more for latency
  logic [SC_W-1:0] w_rel;
  logic [SC_W-1:0] w_lat;
  logic            w_mode;

  // Weighted occupancy sums straight from the registered occupancies
  always_comb begin
    w_rel = '0;
    w_lat = '0;
    for (int i = 0; i < NUM_CH; i++) begin
      w_rel = w_rel + SC_W'(i + 1) * SC_W'(w_occ[i]);
      w_lat = w_lat + SC_W'(NUM_CH - i) * SC_W'(w_occ[i]);
    end
  end

  assign w_mode    = (w_rel >= w_lat) ? MODE_REL : MODE_LAT;
  assign rel_score = w_rel;
  assign lat_score = w_lat;
  assign mode      = w_mode;

  // Fullest channel wins; ties go low in latency mode and high in reliability mode
  always_comb begin
    w_sel_ch  = '0;
    w_sel_occ = '0;
    for (int i = 0; i < NUM_CH; i++) begin
      if ((w_mode == MODE_REL) ? (w_occ[i] >= w_sel_occ) : (w_occ[i] > w_sel_occ)) begin
        w_sel_ch  = CH_W'(i);
        w_sel_occ = w_occ[i];
      end
    end
  end

  // A tick with every queue empty is simply consumed
  assign w_pop_go = w_tick && (w_sel_occ != '0);

  logic              r_out_valid;
  logic [CH_W-1:0]   r_out_ch;
  logic [DATA_W-1:0] r_out_data;

  // Present the popped head for one cycle; channel and data hold between pops
  always_ff @(posedge clk) begin
    if (rst) begin
      r_out_valid <= 1'b0;
      r_out_ch    <= '0;
      r_out_data  <= '0;
    end else begin
      r_out_valid <= w_pop_go;
      if (w_pop_go) begin
        r_out_ch   <= w_sel_ch;
        r_out_data <= w_head[w_sel_ch];
      end
    end
  end

  assign out_valid = r_out_valid;
  assign out_ch    = r_out_ch;
  assign out_data  = r_out_data;

endmodule

// File: tb/tb_packet_queue_scheduler.sv
// tb/tb_packet_queue_scheduler.sv - directed self-checking bench with queue model and output scoreboard
module tb_packet_queue_scheduler;

  localparam int NUM_CH   = 4;
  localparam int DEPTH    = 6;
  localparam int DATA_W   = 2;
  localparam int TICK_DIV = 8;
  localparam int CH_W     = 2;
  localparam int OCC_W    = 3;
  localparam int SC_W     = 6;
  localparam int PKT_W    = CH_W + DATA_W;

  logic                    clk = 1'b0;
  logic                    rst;
  logic                    in_valid;
  logic                    in_bit;
  logic                    out_valid;
  logic [CH_W-1:0]         out_ch;
  logic [DATA_W-1:0]       out_data;
  logic [NUM_CH*OCC_W-1:0] occ;
  logic [SC_W-1:0]         rel_score;
  logic [SC_W-1:0]         lat_score;
  logic                    mode;
  logic                    drop;

  always #5 clk = ~clk;

  packet_queue_scheduler #(
    .NUM_CH   (NUM_CH),
    .DEPTH    (DEPTH),
    .DATA_W   (DATA_W),
    .TICK_DIV (TICK_DIV)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_bit    (in_bit),
    .out_valid (out_valid),
    .out_ch    (out_ch),
    .out_data  (out_data),
    .occ       (occ),
    .rel_score (rel_score),
    .lat_score (lat_score),
    .mode      (mode),
    .drop      (drop)
  );

  int n_assert = 0;
  int n_fail   = 0;

  // Reference state
  logic [DATA_W-1:0]        mq [NUM_CH][$];
  logic [CH_W+DATA_W-1:0]   exp_q [$];
  logic [PKT_W-2:0]         m_shift;
  int                       m_bitcnt;
  int                       m_tick;
  logic [CH_W-1:0]          m_last_ch;
  logic [DATA_W-1:0]        m_last_data;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic int m_rel();
    int s = 0;
    for (int i = 0; i < NUM_CH; i++) s += (i + 1) * mq[i].size();
    return s;
  endfunction

  function automatic int m_lat();
    int s = 0;
    for (int i = 0; i < NUM_CH; i++) s += (NUM_CH - i) * mq[i].size();
    return s;
  endfunction

  task automatic model_reset();
    for (int i = 0; i < NUM_CH; i++) mq[i].delete();
    exp_q.delete();
    m_shift     = '0;
    m_bitcnt    = 0;
    m_tick      = 0;
    m_last_ch   = '0;
    m_last_data = '0;
  endtask

  // One clock with the given serial input; the model predicts the edge, then the DUT is checked
  task automatic cycle(input logic v, input logic b);
    logic                     exp_valid;
    logic                     exp_drop;
    logic                     rel_mode;
    logic [PKT_W-1:0]         pkt;
    logic [CH_W+DATA_W-1:0]   ent;
    logic [NUM_CH*OCC_W-1:0]  exp_occ;
    int                       maxs;
    int                       sel;
    int                       pch;
    exp_valid = 1'b0;
    exp_drop  = 1'b0;
    sel       = -1;
    if (m_tick == TICK_DIV - 1) begin
      rel_mode = (m_rel() >= m_lat());
      maxs = 0;
      for (int i = 0; i < NUM_CH; i++) if (mq[i].size() > maxs) maxs = mq[i].size();
      if (maxs > 0) begin
        if (rel_mode) begin
          for (int i = NUM_CH - 1; i >= 0; i--) if (sel < 0 && mq[i].size() == maxs) sel = i;
        end else begin
          for (int i = 0; i < NUM_CH; i++) if (sel < 0 && mq[i].size() == maxs) sel = i;
        end
        exp_q.push_back({CH_W'(sel), mq[sel].pop_front()});
        exp_valid = 1'b1;
      end
    end
    m_tick = (m_tick == TICK_DIV - 1) ? 0 : m_tick + 1;
    if (v) begin
      pkt     = {m_shift, b};
      m_shift = pkt[PKT_W-2:0];
      if (m_bitcnt == PKT_W - 1) begin
        pch = int'(pkt[PKT_W-1 -: CH_W]);
        if (mq[pch].size() == DEPTH) begin
          void'(mq[pch].pop_front());
          exp_drop = 1'b1;
        end
        mq[pch].push_back(pkt[DATA_W-1:0]);
        m_bitcnt = 0;
      end else begin
        m_bitcnt++;
      end
    end
    in_valid = v;
    in_bit   = b;
    @(posedge clk);
    #1;
    if (exp_valid) begin
      ent         = exp_q.pop_front();
      m_last_ch   = ent[CH_W+DATA_W-1 -: CH_W];
      m_last_data = ent[DATA_W-1:0];
    end
    for (int i = 0; i < NUM_CH; i++) exp_occ[i*OCC_W +: OCC_W] = OCC_W'(mq[i].size());
    chk("out_valid", out_valid, exp_valid);
    chk("out_ch", out_ch, m_last_ch);
    chk("out_data", out_data, m_last_data);
    chk("drop", drop, exp_drop);
    chk("occ", occ, exp_occ);
    chk("rel_score", rel_score, m_rel());
    chk("lat_score", lat_score, m_lat());
    chk("mode", mode, m_rel() >= m_lat());
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) cycle(1'b0, 1'b0);
  endtask

  task automatic send_pkt(input int ch, input int data);
    logic [PKT_W-1:0] bits;
    bits = {CH_W'(ch), DATA_W'(data)};
    for (int i = PKT_W - 1; i >= 0; i--) cycle(1'b1, bits[i]);
  endtask

  task automatic do_reset();
    rst      = 1'b1;
    in_valid = 1'b0;
    in_bit   = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_out_valid", out_valid, 0);
    chk("rst_out_ch", out_ch, 0);
    chk("rst_out_data", out_data, 0);
    chk("rst_drop", drop, 0);
    chk("rst_occ", occ, 0);
    chk("rst_rel", rel_score, 0);
    chk("rst_lat", lat_score, 0);
    chk("rst_mode", mode, 1);
    rst = 1'b0;
    model_reset();
  endtask

  initial begin
    rst      = 1'b1;
    in_valid = 1'b0;
    in_bit   = 1'b0;
    model_reset();

    // Reset, then an empty tick, then a single packet to channel 2
    do_reset();
    idle(9);
    send_pkt(2, 3);
    chk("asm_occ2", occ[2*OCC_W +: OCC_W], 1);
    chk("asm_rel", rel_score, 3);
    chk("asm_lat", lat_score, 2);
    chk("asm_mode", mode, 1);
    idle(12);

    // Reset after three bits of a packet; the next four bits stand alone
    cycle(1'b1, 1'b1);
    cycle(1'b1, 1'b1);
    cycle(1'b1, 1'b1);
    do_reset();
    send_pkt(1, 2);
    chk("midrst_occ1", occ[1*OCC_W +: OCC_W], 1);
    chk("midrst_occ3", occ[3*OCC_W +: OCC_W], 0);
    idle(10);

    // Tie in reliability mode, then a latency-mode state; ticks land at phase 7 of each window
    do_reset();
    idle(4);
    send_pkt(0, 1);
    send_pkt(3, 2);
    chk("tie_rel", rel_score, 5);
    chk("tie_lat", lat_score, 5);
    chk("tie_mode", mode, 1);
    send_pkt(3, 0);
    send_pkt(3, 3);
    send_pkt(0, 2);
    send_pkt(3, 1);
    send_pkt(3, 3);
    send_pkt(1, 0);
    chk("lat_rel", rel_score, 12);
    chk("lat_lat", lat_score, 13);
    chk("lat_mode", mode, 0);
    idle(40);

    // Fill channel 1 to overflow; every second packet completes on a tick that pops channel 1
    do_reset();
    for (int k = 0; k < 14; k++) begin
      send_pkt(1, k % 4);
      if (k == 12) begin
        chk("ovf_drop", drop, 1);
        chk("ovf_occ1", occ[1*OCC_W +: OCC_W], 6);
      end
      if (k == 13) begin
        chk("coinc_drop", drop, 0);
        chk("coinc_occ1", occ[1*OCC_W +: OCC_W], 6);
      end
    end
    idle(56);
    chk("drained_occ", occ, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
